// File: rtl/bus_dec.sv
// -----------------------------------------------------------------------------
// bus_dec - ECO32 system bus address decoder / interconnect
//
// Connects one bus master to NSLV slaves. The word address is matched against
// per-slave match/mask pairs, and the lowest-indexed hit wins. The strobe is
// routed to that slave, and its read data and acknowledge are muxed back.
//
// Optional feature (macro BUS_TIMEOUT_EN):
//   A watchdog ends any access that is not acknowledged within TMO_CYCLES.
//   It gives the master a dummy ack with zero data, latches the faulting
//   address and direction, and raises a level interrupt (tmo_irq).
//   Without the macro, the fault outputs are tied to 0 and an unacknowledged
//   access stalls the master.
//
// Ports:
//   clk, rst         system clock, synchronous active-high reset
//   bus_stb/we/addr  master strobe, write enable, word address [31:2]
//   bus_din/ack      read data and acknowledge to the master
//   slv_stb          per-slave strobe
//   slv_dout/ack     packed per-slave read data and acknowledge
//   tmo_clr          pulse: clear tmo_irq
//   fault_addr/we    byte address and direction of last timed-out access
//   tmo_irq          fault interrupt request (level)
// -----------------------------------------------------------------------------
module bus_dec #(
    parameter int                   NSLV       = 8,
    parameter logic [NSLV*30-1:0]   SLV_MATCH  = '0,
    parameter logic [NSLV*30-1:0]   SLV_MASK   = '0,
    parameter int                   TMO_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bus_stb,
    input  logic                 bus_we,
    input  logic [29:0]          bus_addr,
    output logic [31:0]          bus_din,
    output logic                 bus_ack,
    output logic [NSLV-1:0]      slv_stb,
    input  logic [NSLV*32-1:0]   slv_dout,
    input  logic [NSLV-1:0]      slv_ack,
    input  logic                 tmo_clr,
    output logic [31:0]          fault_addr,
    output logic                 fault_we,
    output logic                 tmo_irq
);

    logic [NSLV-1:0] hit;
    logic [NSLV-1:0] sel;
    logic [31:0]     mux_din;
    logic            mux_ack;
    logic            in_tmo;

    // Address decode with lowest-index priority, then data/ack mux.
    always_comb begin
        logic found;
        hit     = '0;
        sel     = '0;
        mux_din = '0;
        mux_ack = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            hit[i] = ((bus_addr & SLV_MASK[30*i +: 30]) == SLV_MATCH[30*i +: 30]);
            if (hit[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
        for (int i = 0; i < NSLV; i++) begin
            if (sel[i]) begin
                mux_din = slv_dout[32*i +: 32];
                mux_ack = slv_ack[i];
            end
        end
    end

    // In the timeout cycle the slave is already cut off, so a late slave ack
    // cannot reach the master a second time.
    assign slv_stb = in_tmo ? '0 : (sel & {NSLV{bus_stb}});
    assign bus_din = (bus_stb && !in_tmo) ? mux_din : 32'h0;
    assign bus_ack = mux_ack | in_tmo;

`ifdef BUS_TIMEOUT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        TMO  = 2'd2
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] fault_addr_q, fault_addr_d;
    logic        fault_we_q, fault_we_d;
    logic        tmo_irq_q, tmo_irq_d;
    logic        enter_tmo;

    assign in_tmo = (state_q == TMO);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fault_addr_q <= '0;
            fault_we_q   <= 1'b0;
            tmo_irq_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fault_addr_q <= fault_addr_d;
            fault_we_q   <= fault_we_d;
            tmo_irq_q    <= tmo_irq_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fault_addr_d = fault_addr_q;
        fault_we_d   = fault_we_q;
        tmo_irq_d    = tmo_irq_q;

        // A dropped strobe takes WAIT back to IDLE before the timeout check.
        enter_tmo = (state_q == WAIT) && bus_stb && !bus_ack && (cnt_q == TMO_LAST);

        case (state_q)
            IDLE: if (bus_stb && !bus_ack) state_d = WAIT;
            WAIT: begin
                if (bus_ack || !bus_stb) state_d = IDLE;
                else if (enter_tmo)      state_d = TMO;
            end
            TMO:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // cnt equals the cycle index of the pending access; it is zero
        // whenever no access is outstanding.
        if (in_tmo || bus_ack || !bus_stb) cnt_d = '0;
        else                               cnt_d = cnt_q + 16'd1;

        // Set has priority over a same-cycle clear.
        if (enter_tmo) begin
            fault_addr_d = {bus_addr, 2'b00};
            fault_we_d   = bus_we;
            tmo_irq_d    = 1'b1;
        end else if (tmo_clr) begin
            tmo_irq_d    = 1'b0;
        end
    end

    assign fault_addr = fault_addr_q;
    assign fault_we   = fault_we_q;
    assign tmo_irq    = tmo_irq_q;
`else
    logic unused_tie;

    assign in_tmo     = 1'b0;
    assign fault_addr = 32'h0;
    assign fault_we   = 1'b0;
    assign tmo_irq    = 1'b0;
    assign unused_tie = ^{clk, rst, bus_we, tmo_clr};
`endif

endmodule

// File: tb/tb_bus_dec.sv
module tb_bus_dec;

    localparam int NSLV = 3;
    localparam int TMO  = 8;
`ifdef BUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int STALL_LIM = 20;

    logic              clk = 1'b0;
    logic              rst;
    logic              bus_stb;
    logic              bus_we;
    logic [29:0]       bus_addr;
    logic [31:0]       bus_din;
    logic              bus_ack;
    logic [NSLV-1:0]   slv_stb;
    logic [NSLV*32-1:0] slv_dout;
    logic [NSLV-1:0]   slv_ack;
    logic              tmo_clr;
    logic [31:0]       fault_addr;
    logic              fault_we;
    logic              tmo_irq;

    bus_dec #(
        .NSLV      (NSLV),
        .SLV_MATCH ({30'h0C000000, 30'h08000000, 30'h00000000}),
        .SLV_MASK  ({30'h3FFC0000, 30'h3FFFC000, 30'h3F800000}),
        .TMO_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_stb   (bus_stb),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_din   (bus_din),
        .bus_ack   (bus_ack),
        .slv_stb   (slv_stb),
        .slv_dout  (slv_dout),
        .slv_ack   (slv_ack),
        .tmo_clr   (tmo_clr),
        .fault_addr(fault_addr),
        .fault_we  (fault_we),
        .tmo_irq   (tmo_irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: what the fault registers should hold.
    logic        m_irq;
    logic [31:0] m_faddr;
    logic        m_fwe;

    // Memory map in byte-address terms.
    logic [31:0] map_base [NSLV] = '{32'h00000000, 32'h20000000, 32'h30000000};
    logic [31:0] map_mask [NSLV] = '{32'hFE000000, 32'hFFFF0000, 32'hFFF00000};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_sel(input logic [31:0] a);
        for (int i = 0; i < NSLV; i++)
            if ((a & map_mask[i]) == map_base[i]) return i;
        return -1;
    endfunction

    task automatic chk_fault();
        chk("tmo_irq", {31'h0, tmo_irq}, {31'h0, m_irq});
        chk("fault_addr", fault_addr, m_faddr);
        chk("fault_we", {31'h0, fault_we}, {31'h0, m_fwe});
    endtask

    // Master idle for n cycles, optionally pulsing tmo_clr in the first one.
    task automatic idle(input int n, input bit clr);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            rst      = 1'b0;
            bus_stb  = 1'b0;
            bus_we   = 1'($urandom);
            bus_addr = 30'($urandom);
            slv_ack  = '0;
            slv_dout = {$urandom, $urandom, $urandom};
            tmo_clr  = clr && (k == 0);
            @(negedge clk);
            chk("idle_ack", {31'h0, bus_ack}, 32'h0);
            chk("idle_din", bus_din, 32'h0);
            chk("idle_stb", {29'h0, slv_stb}, 32'h0);
            chk_fault();
            if (TMO_EN && tmo_clr) m_irq = 1'b0;
        end
    endtask

    // One master access. lat = cycle of the target slave's ack (-1: never).
    // clr_at = cycle in which tmo_clr is pulsed (-1: none).
    task automatic run_access(input logic [31:0] a, input bit we, input int lat, input int clr_at);
        int s;
        int lim;
        bit is_tmo;
        logic [NSLV-1:0] oh;
        logic [31:0] dv [NSLV];
        logic exp_ack;
        s      = model_sel(a);
        oh     = (s >= 0) ? NSLV'(1 << s) : '0;
        is_tmo = TMO_EN && (s < 0 || lat < 0 || lat >= TMO);
        lim    = TMO_EN ? TMO : STALL_LIM;
        for (int k = 0; k <= lim; k++) begin
            @(posedge clk); #1;
            rst      = 1'b0;
            bus_stb  = 1'b1;
            bus_we   = we;
            bus_addr = a[31:2];
            for (int i = 0; i < NSLV; i++) dv[i] = $urandom;
            slv_dout = {dv[2], dv[1], dv[0]};
            slv_ack  = (NSLV'($urandom) & ~oh) | ((k == lat) ? oh : '0);
            tmo_clr  = (k == clr_at);
            @(negedge clk);
            if (is_tmo) exp_ack = (k == TMO);
            else        exp_ack = (s >= 0) && (k == lat);
            chk("ack", {31'h0, bus_ack}, {31'h0, exp_ack});
            if (is_tmo && k == TMO) begin
                chk("tmo_din", bus_din, 32'h0);
                chk("tmo_stb", {29'h0, slv_stb}, 32'h0);
            end else begin
                chk("din", bus_din, (s >= 0) ? dv[s] : 32'h0);
                chk("stb", {29'h0, slv_stb}, {29'h0, oh});
            end
            chk_fault();
            if (is_tmo && k == TMO - 1) begin
                m_irq   = 1'b1;
                m_faddr = {a[31:2], 2'b00};
                m_fwe   = we;
            end else if (TMO_EN && tmo_clr) begin
                m_irq = 1'b0;
            end
            if (exp_ack) break;
        end
    endtask

    // Reset arrives in cycle 4 of a never-acknowledged access to slave 2.
    task automatic reset_mid();
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk); #1;
            rst      = (k == 4);
            bus_stb  = 1'b1;
            bus_we   = 1'b0;
            bus_addr = 30'h0C000040;
            slv_ack  = '0;
            slv_dout = {$urandom, $urandom, $urandom};
            tmo_clr  = 1'b0;
            @(negedge clk);
            chk("rst_ack", {31'h0, bus_ack}, 32'h0);
            chk("rst_stb", {29'h0, slv_stb}, 32'h4);
            chk_fault();
        end
        m_irq   = 1'b0;
        m_faddr = '0;
        m_fwe   = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 4))
            0:       return r & 32'h01FFFFFC;
            1:       return 32'h20000000 | (r & 32'h0000FFFC);
            2:       return 32'h30000000 | (r & 32'h000FFFFC);
            3:       return 32'h40000000 | (r & 32'h0FFFFFFC);
            default: return 32'h20010000 | (r & 32'h0000FFFC);
        endcase
    endfunction

    initial begin
        int lat;
        int clr_at;
        rst      = 1'b1;
        bus_stb  = 1'b0;
        bus_we   = 1'b0;
        bus_addr = '0;
        slv_dout = '0;
        slv_ack  = '0;
        tmo_clr  = 1'b0;
        m_irq    = 1'b0;
        m_faddr  = '0;
        m_fwe    = 1'b0;

        // Reset: strobe routing stays combinational while rst is held.
        @(posedge clk); #1;
        bus_stb  = 1'b1;
        bus_addr = 30'h08000004;
        @(negedge clk);
        chk("rst_route", {29'h0, slv_stb}, 32'h2);
        @(posedge clk); #1;
        bus_stb = 1'b0;
        @(negedge clk);
        chk("reset_ack", {31'h0, bus_ack}, 32'h0);
        chk_fault();

        // Directed cases.
        run_access(32'h20000010, 1'b0, 0, -1);
        run_access(32'h01FFFFFC, 1'b0, 5, -1);
        idle(1, 1'b0);
        run_access(32'h40000000, 1'b1, -1, -1);
        idle(1, 1'b0);
        run_access(32'h30000040, 1'b0, TMO, -1);
        idle(1, 1'b1);
        run_access(32'h50000000, 1'b0, -1, TMO - 1);
        idle(2, 1'b0);
        idle(2, 1'b1);
        run_access(32'h44440000, 1'b1, -1, -1);
        reset_mid();
        idle(1, 1'b0);
        run_access(32'h40000100, 1'b0, -1, -1);

        // Randomized traffic, including back-to-back accesses.
        for (int n = 0; n < 60; n++) begin
            lat    = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 10));
            clr_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 9)) : -1;
            run_access(rand_addr(), 1'($urandom), lat, clr_at);
            idle($urandom_range(0, 2), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
